// File: rtl/mem_io_bridge.sv
// Multi-cycle CPU memory port bridge to async SRAM and memory-mapped switches/hex I/O.
// Optional MEM_IO_SWSYNC_EN: route Switches through a 2-flop synchroniser before IO reads.
module mem_io_bridge #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       SRAM_ADDR_W = 20,
    parameter int unsigned       WAIT_STATES = 2,
    parameter int unsigned       NUM_HEX     = 4,
    parameter logic [ADDR_W-1:0] IO_ADDR     = 16'hFFFF
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     req,
    input  logic                     rw_we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ack,
    output logic                     busy,
    input  logic [DATA_W-1:0]        Switches,
    output logic [4*NUM_HEX-1:0]     hex_out,
    output logic                     CE,
    output logic                     UB,
    output logic                     LB,
    output logic                     OE,
    output logic                     WE,
    output logic [SRAM_ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]        sram_wdata,
    input  logic [DATA_W-1:0]        sram_rdata,
    output logic                     sram_drive
);

    localparam int unsigned HEX_W   = 4 * NUM_HEX;
    localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q;
    logic [3:0]        wait_cnt_q;
    logic              rw_q;
    logic [DATA_W-1:0] sw_val;

`ifdef MEM_IO_SWSYNC_EN
    logic [DATA_W-1:0] sw_meta_q;
    logic [DATA_W-1:0] sw_sync_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= Switches;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign sw_val = sw_sync_q;
`else
    assign sw_val = Switches;
`endif

    // All outputs are registered so strobes change only on clock edges (or async reset).
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            rw_q       <= 1'b0;
            rdata      <= '0;
            hex_out    <= '0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            CE         <= 1'b1;
            UB         <= 1'b1;
            LB         <= 1'b1;
            OE         <= 1'b1;
            WE         <= 1'b1;
            sram_drive <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            ack <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        rw_q <= rw_we;
                        busy <= 1'b1;
                        if (addr == IO_ADDR) begin
                            state_q <= StDone;
                            ack     <= 1'b1;
                            if (rw_we) hex_out <= wdata[HEX_W-1:0];
                            else       rdata   <= sw_val;
                        end else begin
                            state_q    <= StAccess;
                            wait_cnt_q <= '0;
                            CE         <= 1'b0;
                            UB         <= 1'b0;
                            LB         <= 1'b0;
                            OE         <= rw_we;
                            WE         <= !rw_we;
                            sram_drive <= rw_we;
                            sram_addr  <= SRAM_ADDR_W'(addr);
                            sram_wdata <= wdata;
                        end
                    end
                end
                StAccess: begin
                    if (wait_cnt_q == WS_LAST) begin
                        state_q    <= StDone;
                        ack        <= 1'b1;
                        wait_cnt_q <= '0;
                        CE         <= 1'b1;
                        UB         <= 1'b1;
                        LB         <= 1'b1;
                        OE         <= 1'b1;
                        WE         <= 1'b1;
                        sram_drive <= 1'b0;
                        if (!rw_q) rdata <= sram_rdata;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge: one DUT with 2 wait states, one with 0.
module tb_mem_io_bridge;

    logic        Clk;
    logic        Reset;
    logic        req;
    logic        rw_we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] Switches;
    logic [15:0] sram_rdata;

    logic [15:0] rdata, hex_out, sram_wdata;
    logic        ack, busy, CE, UB, LB, OE, WE, sram_drive;
    logic [19:0] sram_addr;

    logic [15:0] b_rdata, b_hex_out, b_sram_wdata;
    logic        b_ack, b_busy, b_CE, b_UB, b_LB, b_OE, b_WE, b_sram_drive;
    logic [19:0] b_sram_addr;

    int checks;
    int errors;

    mem_io_bridge #(.WAIT_STATES(2)) u_dut_ws2 (
        .Clk(Clk), .Reset(Reset), .req(req), .rw_we(rw_we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .Switches(Switches), .hex_out(hex_out),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_drive(sram_drive)
    );

    mem_io_bridge #(.WAIT_STATES(0)) u_dut_ws0 (
        .Clk(Clk), .Reset(Reset), .req(req), .rw_we(rw_we), .addr(addr), .wdata(wdata),
        .rdata(b_rdata), .ack(b_ack), .busy(b_busy), .Switches(Switches), .hex_out(b_hex_out),
        .CE(b_CE), .UB(b_UB), .LB(b_LB), .OE(b_OE), .WE(b_WE), .sram_addr(b_sram_addr),
        .sram_wdata(b_sram_wdata), .sram_rdata(sram_rdata), .sram_drive(b_sram_drive)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
        checks++; if (hex_out !== 16'h0) begin errors++; $display("FAIL rst_hex: got %h want 0000", hex_out); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if ({CE, UB, LB, OE, WE} !== 5'b11111) begin errors++; $display("FAIL rst_strobes: got %b want 11111", {CE, UB, LB, OE, WE}); end
        checks++; if (sram_drive !== 1'b0) begin errors++; $display("FAIL rst_drive: got %b want 0", sram_drive); end
        checks++; if (sram_addr !== 20'h0) begin errors++; $display("FAIL rst_sram_addr: got %h want 00000", sram_addr); end
        tick();
        tick();
        checks++; if (busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy: got %b%b want 00", busy, b_busy); end
        #2;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_sram_write();
        int we_low = 0;
        int ack_cyc = -1;
        int ack_n = 0;
        int bad = 0;
        rw_we = 1'b1; addr = 16'h0010; wdata = 16'h1234; req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) req = 1'b0;
            // A request while busy must be dropped, not queued.
            if (c == 2) begin req = 1'b1; rw_we = 1'b0; addr = 16'h0099; end
            if (c == 3) req = 1'b0;
            if (WE === 1'b0) begin
                we_low++;
                if (sram_addr !== 20'h00010 || sram_wdata !== 16'h1234 || {CE, UB, LB, OE} !== 4'b0001
                    || sram_drive !== 1'b1) bad++;
            end
            if (OE === 1'b0) bad++;
            if (ack === 1'b1) begin ack_n++; ack_cyc = c; end
        end
        checks++; if (we_low !== 3) begin errors++; $display("FAIL wr_we_cycles: got %0d want 3", we_low); end
        checks++; if (ack_cyc !== 4) begin errors++; $display("FAIL wr_ack_cycle: got %0d want 4", ack_cyc); end
        checks++; if (ack_n !== 1) begin errors++; $display("FAIL wr_ack_count: got %0d want 1", ack_n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wr_bus_values: got %0d bad cycles want 0", bad); end
        checks++; if (rdata !== 16'h0 || hex_out !== 16'h0) begin errors++; $display("FAIL wr_side_effect: got rdata %h hex %h want 0000 0000", rdata, hex_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_sram_read();
        int oe_low = 0;
        int ack_cyc = -1;
        int bad = 0;
        logic [15:0] rd_at_ack = 16'h0;
        sram_rdata = 16'h1234; rw_we = 1'b0; addr = 16'h0010; req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) req = 1'b0;
            if (OE === 1'b0) begin
                oe_low++;
                if (sram_addr !== 20'h00010 || CE !== 1'b0) bad++;
            end
            if (WE === 1'b0 || sram_drive === 1'b1) bad++;
            if (ack === 1'b1) begin ack_cyc = c; rd_at_ack = rdata; end
        end
        checks++; if (oe_low !== 3) begin errors++; $display("FAIL rd_oe_cycles: got %0d want 3", oe_low); end
        checks++; if (ack_cyc !== 4) begin errors++; $display("FAIL rd_ack_cycle: got %0d want 4", ack_cyc); end
        checks++; if (rd_at_ack !== 16'h1234) begin errors++; $display("FAIL rd_data: got %h want 1234", rd_at_ack); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rd_bus_values: got %0d bad cycles want 0", bad); end
        sram_rdata = 16'h0000;
        tick();
        checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL rd_hold: got %h want 1234", rdata); end
    endtask

    task automatic test_io_write();
        int ack_cyc = -1;
        int ack_n = 0;
        int bad = 0;
        rw_we = 1'b1; addr = 16'hFFFF; wdata = 16'hBEEF; req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) req = 1'b0;
            if ({CE, UB, LB, OE, WE} !== 5'b11111 || sram_drive !== 1'b0) bad++;
            if (ack === 1'b1) begin ack_n++; ack_cyc = c; end
        end
        checks++; if (ack_cyc !== 1) begin errors++; $display("FAIL iow_ack_cycle: got %0d want 1", ack_cyc); end
        checks++; if (ack_n !== 1) begin errors++; $display("FAIL iow_ack_count: got %0d want 1", ack_n); end
        checks++; if (hex_out !== 16'hBEEF) begin errors++; $display("FAIL iow_hex: got %h want beef", hex_out); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL iow_strobes: got %0d bad cycles want 0", bad); end
        checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL iow_rdata_kept: got %h want 1234", rdata); end
    endtask

    task automatic test_io_read();
        int ack_cyc = -1;
        int bad = 0;
        logic [15:0] rd_at_ack = 16'h0;
        Switches = 16'h00A5;
        for (int i = 0; i < 4; i++) tick();
        rw_we = 1'b0; addr = 16'hFFFF; req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) req = 1'b0;
            if ({CE, UB, LB, OE, WE} !== 5'b11111 || sram_drive !== 1'b0) bad++;
            if (ack === 1'b1) begin ack_cyc = c; rd_at_ack = rdata; end
        end
        checks++; if (ack_cyc !== 1) begin errors++; $display("FAIL ior_ack_cycle: got %0d want 1", ack_cyc); end
        checks++; if (rd_at_ack !== 16'h00A5) begin errors++; $display("FAIL ior_data: got %h want 00a5", rd_at_ack); end
        checks++; if (hex_out !== 16'hBEEF) begin errors++; $display("FAIL ior_hex_kept: got %h want beef", hex_out); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ior_strobes: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ack_mask = '0;
        logic [15:0] oe_mask = '0;
        int bad = 0;
        sram_rdata = 16'h5555; rw_we = 1'b0; addr = 16'h0020; req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 8) req = 1'b0;
            if (b_ack === 1'b1) begin
                ack_mask[c] = 1'b1;
                if (b_rdata !== 16'h5555) bad++;
            end
            if (b_OE === 1'b0) begin
                oe_mask[c] = 1'b1;
                if (b_sram_addr !== 20'h00020) bad++;
            end
        end
        checks++; if (ack_mask !== 16'h0124) begin errors++; $display("FAIL b2b_ack_cycles: got %h want 0124", ack_mask); end
        checks++; if (oe_mask !== 16'h0092) begin errors++; $display("FAIL b2b_oe_cycles: got %h want 0092", oe_mask); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_data: got %0d bad cycles want 0", bad); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_mid_access();
        int ack_n = 0;
        rw_we = 1'b1; addr = 16'h0030; wdata = 16'h5A5A; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        checks++; if (WE !== 1'b0) begin errors++; $display("FAIL rmid_pre_we: got %b want 0", WE); end
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (WE !== 1'b1 || CE !== 1'b1) begin errors++; $display("FAIL rmid_strobes: got WE=%b CE=%b want 1 1", WE, CE); end
        checks++; if (sram_drive !== 1'b0) begin errors++; $display("FAIL rmid_drive: got %b want 0", sram_drive); end
        checks++; if (busy !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL rmid_busy_ack: got %b%b want 00", busy, ack); end
        checks++; if (hex_out !== 16'h0 || rdata !== 16'h0) begin errors++; $display("FAIL rmid_regs: got hex %h rdata %h want 0000 0000", hex_out, rdata); end
        #2;
        Reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack === 1'b1 || busy === 1'b1) ack_n++;
        end
        checks++; if (ack_n !== 0) begin errors++; $display("FAIL rmid_no_ack: got %0d active cycles want 0", ack_n); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        req = 1'b0;
        rw_we = 1'b0;
        addr = '0;
        wdata = '0;
        Switches = '0;
        sram_rdata = '0;
        test_reset();
        test_sram_write();
        test_sram_read();
        test_io_write();
        test_io_read();
        test_back_to_back();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
